// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between the single-cycle ALU
// writeback path and the long-latency LSU/MUL writeback path, registers the
// winning write toward the register file, and keeps a scoreboard of
// destination registers that still have a long-latency write outstanding.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_wb_valid/addr/data, ready    ALU writeback request and grant
//   lsu_wb_valid/addr/data, ready    long-unit writeback request and grant
//   issue_valid, issue_long          decode presents an instruction; long-unit op
//   issue_rd, issue_rs1, issue_rs2   decode register fields
//   issue_stall                      presented instruction must hold (RAW/WAW)
//   rf_wen, rf_waddr, rf_wdata       registered write toward the register file
//   fwd_rs1_hit, fwd_rs2_hit         in-flight write matches rs1/rs2
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [AW-1:0]   lsu_wb_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_stall,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit
);

  // Round-robin pointer: 0 favours the ALU, 1 favours the LSU.
  logic            prio_q;
  // Bit 0 is kept for uniform indexing but is forced to zero (x0 never busy).
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  logic            alu_xfer;
  logic            lsu_xfer;
  logic            both_valid;
  logic            set_busy;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // Each ready looks only at the opposite valid and the pointer, so a
  // requester can never see its own valid loop back into its grant.
  assign alu_wb_ready = !lsu_wb_valid || !prio_q;
  assign lsu_wb_ready = !alu_wb_valid ||  prio_q;

  assign alu_xfer   = alu_wb_valid && alu_wb_ready;
  assign lsu_xfer   = lsu_wb_valid && lsu_wb_ready;
  assign both_valid = alu_wb_valid && lsu_wb_valid;

  // Hazard check covers RAW on both sources and WAW on the destination.
  assign issue_stall = issue_valid &&
                       (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);

  assign set_busy = issue_valid && issue_long && !issue_stall && (issue_rd != '0);

  // At most one transfer per cycle: when both are valid exactly one is ready.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    wr_valid = alu_xfer || lsu_xfer;
    wr_addr  = alu_wb_addr;
    wr_data  = alu_wb_data;
    if (lsu_xfer) begin
      wr_addr = lsu_wb_addr;
      wr_data = lsu_wb_data;
    end
  end

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (lsu_xfer) busy_nxt[lsu_wb_addr] = 1'b0;
    if (set_busy) busy_nxt[issue_rd]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      prio_q   <= 1'b0;
      busy_q   <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      rf_wen <= wr_valid && (wr_addr != '0);
      // Address and data only move on a real write; x0 writes are dropped
      // after completing the handshake.
      if (wr_valid && (wr_addr != '0)) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      // Under contention the prio side wins, so the pointer moves to the loser.
      if (both_valid) prio_q <= !prio_q;
      busy_q <= busy_nxt;
    end
  end

  // The register file still returns the old value while this write is in
  // the output register, so decode takes rf_wdata instead.
  assign fwd_rs1_hit = rf_wen && (rf_waddr == issue_rs1) && (issue_rs1 != '0);
  assign fwd_rs2_hit = rf_wen && (rf_waddr == issue_rs2) && (issue_rs2 != '0);

endmodule
